pipelined_approx_adder: RTL
===========================

// Module: pipelined_approx_adder
// PURPOSE
//  Parametrised, pipelined N-bit adder with a per-transaction exact/approximate mode.
//  The datapath is split into STAGES equal segments with a registered carry between segments.
//  The low APPROX_BITS use a lower-part-OR approximation when approximate mode is selected.
//  Feeds partial-product accumulation in the Vedic multiplier datapath; valid/ready on both sides.
// PARAMETERS
//  N           8  operand/sum width; N % STAGES must be 0
//  STAGES      2  pipeline segments (1..N); latency = STAGES cycles; segment width W = N/STAGES
//  APPROX_BITS 4  LSBs approximated in approx mode (0..N); 0 => approx mode equals exact
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  in_valid   in   1  input transaction valid
//  in_ready   out  1  block can accept input this cycle
//  in_mode    in   1  0 = exact, 1 = approximate
//  A          in   N  operand A
//  B          in   N  operand B
//  Cin        in   1  carry in (ignored in approx mode when APPROX_BITS>0)
//  out_valid  out  1  result valid
//  out_ready  in   1  downstream accepts result
//  Sum        out  N  result
//  Cout       out  1  carry out
//  out_mode   out  1  mode of the transaction being presented
// BEHAVIOUR
//  Reset: all stage valid bits, out_valid, Sum, Cout, out_mode and carry registers = 0; in_ready = 1 after reset.
//  Reset is asynchronous and takes effect mid-operation: in-flight transactions are discarded, none emerge.
//  Arithmetic, exact mode: {Cout,Sum} = A + B + Cin, modulo 2^(N+1).
//  Arithmetic, approx mode, K = APPROX_BITS > 0:
//   - Sum[K-1:0] = A[K-1:0] | B[K-1:0].
//   - Carry into bit K = A[K-1] & B[K-1]; Cin is ignored.
//   - {Cout,Sum[N-1:K]} = A[N-1:K] + B[N-1:K] + that carry.
//   - K = N: Sum = A|B and Cout = A[N-1] & B[N-1].
//  Pipeline: stage s (0..STAGES-1) adds bits [s*W +: W] using the carry registered from stage s-1.
//   - Stage 0 uses Cin, or the approx rule.
//   - Upper operand bits are skewed forward in registers; lower result bits are carried along.
//   - The approx boundary may fall inside any segment; per-bit selection is by bit index, not by segment.
//  Latency: an input accepted at edge t with no stall gives out_valid=1 after edge t+STAGES-1 (STAGES=1: registered output after edge t).
//  Handshake: advance = ~out_valid | out_ready; in_ready = advance (combinational).
//   - All stages shift together on advance; no bubble collapsing.
//   - Accept occurs when in_valid & in_ready; a non-accept cycle inserts a bubble (valid=0) into stage 0.
//   - While out_valid & ~out_ready: every register holds; Sum/Cout/out_mode are stable.
//   - Simultaneous output consume and input accept in the same cycle is allowed: full throughput of 1 result per cycle.
//  out_mode travels with its data; mode may change every transaction.
//  No X propagation: bubble stages may hold stale data, but out_valid=0 marks them.
// TESTING (N=8, STAGES=2, APPROX_BITS=4 unless noted)
//  1. Exact: A=0x0F,B=0x01,Cin=0 -> 2 cycles later Sum=0x10,Cout=0,out_mode=0.
//  2. Approx: A=0x0F,B=0x01 -> Sum=0x0F,Cout=0. Approx: A=0x88,B=0x88 -> Sum=0x18,Cout=1 (exact gives 0x10,1).
//  3. Approx: A=0xFF,B=0x01,Cin=1 -> Sum=0xFF,Cout=0 (Cin ignored).
//     Same inputs, exact -> Sum=0x01,Cout=1.
//  4. Back-to-back: 16 random transactions, alternating modes, in_valid=1, out_ready=1.
//     -> one result per cycle, in order, matching the reference model.
//  5. Backpressure: out_ready=0 for 5 cycles with a full pipe.
//     -> in_ready=0, outputs frozen; after release, no loss or duplication.
//  6. Reset mid-stream with 2 in flight -> out_valid=0 immediately; in_ready=1; no stale result emerges.
//     Repeat 4 with STAGES=1,8 and APPROX_BITS=0,8.

Source files
------------

// File: rtl/pipelined_approx_adder.sv
// pipelined_approx_adder
//   N-bit adder split into STAGES equal segments with a registered carry
//   between segments. Each transaction selects exact or approximate mode; in
//   approximate mode the low APPROX_BITS bits are lower-part-OR and the carry
//   into bit APPROX_BITS is A[K-1] & B[K-1] (Cin ignored).
//   N must be a multiple of STAGES. Latency is STAGES register ranks, and the
//   last rank drives the outputs directly.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  input handshake (in_ready is combinational)
//   in_mode            0 = exact, 1 = approximate
//   A, B, Cin          operands and carry in
//   out_valid/ready    output handshake
//   Sum, Cout          result
//   out_mode           mode of the transaction being presented
module pipelined_approx_adder #(
  parameter int unsigned N           = 8,
  parameter int unsigned STAGES      = 2,
  parameter int unsigned APPROX_BITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         out_mode
);

  localparam int unsigned W = N / STAGES;

  // Whole pipe moves as one; it only holds while a result is being refused.
  logic advance_c;
  assign advance_c = ~out_valid | out_ready;
  assign in_ready  = advance_c;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned LO = s * W;
    localparam int unsigned HI = LO + W;
    localparam int unsigned UP = N - HI;

    logic [W-1:0]  a_seg;
    logic [W-1:0]  b_seg;
    logic [W-1:0]  s_seg;
    logic [HI-1:0] sum_d;
    logic          c_in;
    logic          c_out;
    logic          mode_in;
    logic          valid_in;

    logic [HI-1:0] sum_q;
    logic          carry_q;
    logic          mode_q;
    logic          valid_q;

    // Segment source: primary inputs for stage 0, skewed registers otherwise.
    if (s == 0) begin : g_src
      assign a_seg    = A[W-1:0];
      assign b_seg    = B[W-1:0];
      assign c_in     = Cin;
      assign mode_in  = in_mode;
      assign valid_in = in_valid;
      assign sum_d    = s_seg;
    end else begin : g_src
      assign a_seg    = g_stage[s-1].g_up.a_up_q[W-1:0];
      assign b_seg    = g_stage[s-1].g_up.b_up_q[W-1:0];
      assign c_in     = g_stage[s-1].carry_q;
      assign mode_in  = g_stage[s-1].mode_q;
      assign valid_in = g_stage[s-1].valid_q;
      assign sum_d    = {s_seg, g_stage[s-1].sum_q};
    end

    // Per-bit ripple. An approximate bit ORs its operands and forces the
    // carry to a&b, so the last approximate bit (K-1) yields the carry into
    // bit K, and Cin is discarded whenever bit 0 is approximate.
    always_comb begin
      logic carry_v;
      carry_v = c_in;
      s_seg   = '0;
      for (int j = 0; j < int'(W); j++) begin
        if (mode_in && (int'(LO) + j < int'(APPROX_BITS))) begin
          s_seg[j] = a_seg[j] | b_seg[j];
          carry_v  = a_seg[j] & b_seg[j];
        end else begin
          s_seg[j] = a_seg[j] ^ b_seg[j] ^ carry_v;
          carry_v  = (a_seg[j] & b_seg[j]) | (carry_v & (a_seg[j] ^ b_seg[j]));
        end
      end
      c_out = carry_v;
    end

    // Stage result, carry, mode and valid.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        mode_q  <= 1'b0;
        sum_q   <= '0;
      end else if (advance_c) begin
        valid_q <= valid_in;
        carry_q <= c_out;
        mode_q  <= mode_in;
        sum_q   <= sum_d;
      end
    end

    // Operand bits not yet consumed, skewed forward to later stages.
    if (UP > 0) begin : g_up
      logic [UP-1:0] a_up_d;
      logic [UP-1:0] b_up_d;
      logic [UP-1:0] a_up_q;
      logic [UP-1:0] b_up_q;

      if (s == 0) begin : g_first
        assign a_up_d = A[N-1:HI];
        assign b_up_d = B[N-1:HI];
      end else begin : g_next
        assign a_up_d = g_stage[s-1].g_up.a_up_q[N-LO-1:W];
        assign b_up_d = g_stage[s-1].g_up.b_up_q[N-LO-1:W];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_up_q <= '0;
          b_up_q <= '0;
        end else if (advance_c) begin
          a_up_q <= a_up_d;
          b_up_q <= b_up_d;
        end
      end
    end
  end

  // Final rank is the registered output.
  assign out_valid = g_stage[STAGES-1].valid_q;
  assign Sum       = g_stage[STAGES-1].sum_q;
  assign Cout      = g_stage[STAGES-1].carry_q;
  assign out_mode  = g_stage[STAGES-1].mode_q;

endmodule
